// File: rtl/saph_line_sequencer_if.sv
// rtl/saph_line_sequencer_if.sv - command and fragment handshake bundle for the line sequencer
interface saph_line_sequencer_if #(
    parameter int CW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [CW-1:0] cmd_x0;
    logic [CW-1:0] cmd_y0;
    logic [CW-1:0] cmd_x1;
    logic [CW-1:0] cmd_y1;
    logic          frag_valid;
    logic          frag_ready;
    logic [CW-1:0] frag_x;
    logic [CW-1:0] frag_y;
    logic          frag_last;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, frag_ready,
        input  cmd_ready, frag_valid, frag_x, frag_y, frag_last
    );

    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, frag_ready,
        output cmd_ready, frag_valid, frag_x, frag_y, frag_last
    );
endinterface

// File: rtl/saph_line_sequencer.sv
// rtl/saph_line_sequencer.sv - Bresenham line walker feeding the rasterizer, optional SAPH_LINE_SKIP_LAST_EN
module saph_line_sequencer #(
    parameter int CW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    saph_line_sequencer_if.slave  lif,
    output logic                  ras_latch,
    output logic                  ras_count,
    output logic                  busy
);
    localparam int EW = CW + 3;
    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};
`ifdef SAPH_LINE_SKIP_LAST_EN
    localparam logic [CW-1:0] LAST_REM = ONE;
`else
    localparam logic [CW-1:0] LAST_REM = '0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WALK} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        x0_q, y0_q, x1_q, y1_q;
    logic [CW-1:0]        x0_d, y0_d, x1_d, y1_d;
    logic [CW-1:0]        x_q, y_q, x_d, y_d;
    logic [CW-1:0]        dx_q, dy_q, dx_d, dy_d;
    logic [CW-1:0]        rem_q, rem_d;
    logic signed [EW-1:0] err_q, err_d;
    logic                 sx_neg_q, sy_neg_q, sx_neg_d, sy_neg_d;

    // Deltas are formed one bit wider so a full-range span cannot overflow.
    logic [CW:0]          ddx, ddy;
    logic [CW-1:0]        dx_abs, dy_abs, rem_init;
    logic signed [EW-1:0] err_init, e2, dx_s, dy_s;
    logic                 step_x, step_y, fire;

    assign ddx      = {x1_q[CW-1], x1_q} - {x0_q[CW-1], x0_q};
    assign ddy      = {y1_q[CW-1], y1_q} - {y0_q[CW-1], y0_q};
    assign dx_abs   = ddx[CW] ? (~ddx[CW-1:0] + ONE) : ddx[CW-1:0];
    assign dy_abs   = ddy[CW] ? (~ddy[CW-1:0] + ONE) : ddy[CW-1:0];
    assign rem_init = (dx_abs >= dy_abs) ? dx_abs : dy_abs;
    assign err_init = $signed({3'b000, dx_abs}) - $signed({3'b000, dy_abs});

    assign dx_s   = $signed({3'b000, dx_q});
    assign dy_s   = $signed({3'b000, dy_q});
    assign e2     = err_q <<< 1;
    assign step_x = e2 > -dy_s;
    assign step_y = e2 < dx_s;

    assign lif.cmd_ready  = (state_q == ST_IDLE);
    assign lif.frag_valid = (state_q == ST_WALK);
    assign lif.frag_last  = (state_q == ST_WALK) && (rem_q == LAST_REM);
    assign lif.frag_x     = x_q;
    assign lif.frag_y     = y_q;
    assign busy           = (state_q != ST_IDLE);
    assign ras_latch      = (state_q == ST_SETUP);
    assign fire           = lif.frag_valid & lif.frag_ready;
    assign ras_count      = fire & ~lif.frag_last;

    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        rem_d    = rem_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        case (state_q)
            ST_IDLE: begin
                if (lif.cmd_valid) begin
                    x0_d    = lif.cmd_x0;
                    y0_d    = lif.cmd_y0;
                    x1_d    = lif.cmd_x1;
                    y1_d    = lif.cmd_y1;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                dx_d     = dx_abs;
                dy_d     = dy_abs;
                sx_neg_d = ddx[CW];
                sy_neg_d = ddy[CW];
                err_d    = err_init;
                rem_d    = rem_init;
                x_d      = x0_q;
                y_d      = y0_q;
                state_d  = ST_WALK;
`ifdef SAPH_LINE_SKIP_LAST_EN
                if (rem_init == '0) begin
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_WALK: begin
                if (fire) begin
                    if (lif.frag_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Both steps are decided from the pre-update error term.
                        if (step_x && step_y) begin
                            err_d = err_q - dy_s + dx_s;
                        end else if (step_x) begin
                            err_d = err_q - dy_s;
                        end else if (step_y) begin
                            err_d = err_q + dx_s;
                        end
                        if (step_x) begin
                            x_d = sx_neg_q ? (x_q - ONE) : (x_q + ONE);
                        end
                        if (step_y) begin
                            y_d = sy_neg_q ? (y_q - ONE) : (y_q + ONE);
                        end
                        rem_d = rem_q - ONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            rem_q    <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end
endmodule

// File: tb/tb_saph_line_sequencer.sv
// tb/tb_saph_line_sequencer.sv - directed bench for saph_line_sequencer (default build)
module tb_saph_line_sequencer;
    localparam int CW = 16;

    logic clk;
    logic rst;
    logic ras_latch;
    logic ras_count;
    logic busy;
    int   n_checks;
    int   n_fail;
    int   ex[16];
    int   ey[16];

    saph_line_sequencer_if #(.CW(CW)) lif ();

    saph_line_sequencer #(.CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .lif       (lif),
        .ras_latch (ras_latch),
        .ras_count (ras_count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1);
        lif.cmd_valid = 1'b1;
        lif.cmd_x0 = CW'(x0);
        lif.cmd_y0 = CW'(y0);
        lif.cmd_x1 = CW'(x1);
        lif.cmd_y1 = CW'(y1);
        @(negedge clk);
        check("idle_cmd_ready", lif.cmd_ready, 1);
        tick();
        lif.cmd_valid = 1'b0;
        @(negedge clk);
        check("setup_ras_latch", ras_latch, 1);
        check("setup_busy", busy, 1);
        check("setup_cmd_ready", lif.cmd_ready, 0);
        check("setup_frag_valid", lif.frag_valid, 0);
        tick();
    endtask

    task automatic walk(input int n_total, input int n_take, input int stall_at, input int stall_len);
        lif.frag_ready = 1'b1;
        for (int i = 0; i < n_take; i++) begin
            if (i == stall_at) begin
                lif.frag_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(negedge clk);
                    check("stall_valid", lif.frag_valid, 1);
                    check("stall_x", $signed(lif.frag_x), ex[i]);
                    check("stall_y", $signed(lif.frag_y), ey[i]);
                    check("stall_ras_count", ras_count, 0);
                    tick();
                end
                lif.frag_ready = 1'b1;
            end
            @(negedge clk);
            check("frag_valid", lif.frag_valid, 1);
            check("frag_x", $signed(lif.frag_x), ex[i]);
            check("frag_y", $signed(lif.frag_y), ey[i]);
            check("frag_last", lif.frag_last, longint'(i == n_total - 1));
            check("ras_count", ras_count, longint'(i != n_total - 1));
            check("walk_cmd_ready", lif.cmd_ready, 0);
            tick();
        end
        if (n_take == n_total) begin
            @(negedge clk);
            check("done_valid", lif.frag_valid, 0);
            check("done_busy", busy, 0);
            check("done_cmd_ready", lif.cmd_ready, 1);
            tick();
        end
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        check("rst_frag_valid", lif.frag_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", lif.cmd_ready, 1);
        check("rst_frag_last", lif.frag_last, 0);
        check("rst_ras_latch", ras_latch, 0);
        check("rst_frag_x", lif.frag_x, 0);
        check("rst_frag_y", lif.frag_y, 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b0;
        lif.cmd_valid = 1'b0;
        lif.cmd_x0 = '0;
        lif.cmd_y0 = '0;
        lif.cmd_x1 = '0;
        lif.cmd_y1 = '0;
        lif.frag_ready = 1'b0;
        #3;
        check("reset_frag_valid", lif.frag_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_ras_count", ras_count, 0);
        check("reset_cmd_ready", lif.cmd_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // shallow x-major line
        ex[0:3] = '{0, 1, 2, 3};
        ey[0:3] = '{0, 0, 1, 1};
        send_cmd(0, 0, 3, 1);
        walk(4, 4, -1, 0);

        // steep line, both directions negative
        ex[0:3] = '{2, 2, 1, 1};
        ey[0:3] = '{2, 1, 0, -1};
        send_cmd(2, 2, 1, -1);
        walk(4, 4, -1, 0);

        // degenerate point
        ex[0] = 5;
        ey[0] = 5;
        send_cmd(5, 5, 5, 5);
        walk(1, 1, -1, 0);

        // backpressure on second fragment
        for (int i = 0; i < 8; i++) begin
            ex[i] = i;
            ey[i] = 0;
        end
        send_cmd(0, 0, 7, 0);
        walk(8, 8, 1, 3);

        // extreme coordinates, no wrap
        ex[0:1] = '{32767, 32766};
        ey[0:1] = '{-32768, -32767};
        send_cmd(32767, -32768, 32766, -32767);
        walk(2, 2, -1, 0);

        // reset in the middle of a diagonal
        for (int i = 0; i < 10; i++) begin
            ex[i] = i;
            ey[i] = i;
        end
        send_cmd(0, 0, 9, 9);
        walk(10, 2, -1, 0);
        async_reset();
        ex[0:1] = '{3, 4};
        ey[0:1] = '{3, 4};
        send_cmd(3, 3, 4, 4);
        walk(2, 2, -1, 0);

        // full-range diagonal: first steps only, then abandon by reset
        ex[0:1] = '{-32768, -32767};
        ey[0:1] = '{-32768, -32767};
        send_cmd(-32768, -32768, 32767, 32767);
        walk(65536, 2, -1, 0);
        async_reset();

        // cmd_valid held high across two commands
        lif.frag_ready = 1'b1;
        lif.cmd_valid = 1'b1;
        lif.cmd_x0 = CW'(0);
        lif.cmd_y0 = CW'(0);
        lif.cmd_x1 = CW'(1);
        lif.cmd_y1 = CW'(0);
        @(negedge clk);
        check("hold_accept_a", lif.cmd_ready, 1);
        tick();
        lif.cmd_x0 = CW'(2);
        lif.cmd_y0 = CW'(0);
        lif.cmd_x1 = CW'(2);
        lif.cmd_y1 = CW'(1);
        @(negedge clk);
        check("hold_setup_ready", lif.cmd_ready, 0);
        check("hold_setup_latch", ras_latch, 1);
        tick();
        @(negedge clk);
        check("hold_f0_ready", lif.cmd_ready, 0);
        check("hold_f0_x", $signed(lif.frag_x), 0);
        check("hold_f0_last", lif.frag_last, 0);
        tick();
        @(negedge clk);
        check("hold_f1_ready", lif.cmd_ready, 0);
        check("hold_f1_x", $signed(lif.frag_x), 1);
        check("hold_f1_last", lif.frag_last, 1);
        tick();
        @(negedge clk);
        check("hold_accept_b", lif.cmd_ready, 1);
        check("hold_idle_busy", busy, 0);
        tick();
        lif.cmd_valid = 1'b0;
        @(negedge clk);
        check("hold_b_latch", ras_latch, 1);
        tick();
        ex[0:1] = '{2, 2};
        ey[0:1] = '{0, 1};
        walk(2, 2, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
